// File: rtl/pwm_feeder_pkg.sv
// Shared constants and the clamp helper for the PWM sample feeder.
package pwm_feeder_pkg;

  localparam int CNT_WIDTH = 16;

  // Interprets the low in_w bits of raw as signed and clamps to a signed out_w range.
  function automatic logic signed [31:0] sat(input logic [31:0] raw, input int in_w,
                                             input int out_w);
    logic signed [31:0] v;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    v  = $signed(raw << (32 - in_w)) >>> (32 - in_w);
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    if (v > hi)      sat = hi;
    else if (v < lo) sat = lo;
    else             sat = v;
  endfunction

endpackage

// File: rtl/pwm_sample_feeder_if.sv
// Valid/ready sample stream feeding the PWM sample buffer.
interface pwm_sample_feeder_if #(
  parameter int IN_WIDTH = 16
) ();
  logic signed [IN_WIDTH-1:0] sample_in;
  logic                       sample_valid;
  logic                       sample_ready;

  modport master (output sample_in, output sample_valid, input  sample_ready);
  modport slave  (input  sample_in, input  sample_valid, output sample_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; storage is not reset.
module sync_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   occ;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = occ[DEPTH_LOG2];
  assign empty   = (occ == '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      // Simultaneous push and pop leaves occupancy unchanged.
      if (do_push && !do_pop)      occ <= occ + 1'b1;
      else if (do_pop && !do_push) occ <= occ - 1'b1;
    end
  end

endmodule

// File: rtl/pwm_sample_feeder.sv
// Buffers bursty audio samples and releases one scaled, clamped sample per PWM frame.
module pwm_sample_feeder
  import pwm_feeder_pkg::*;
#(
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 12,
  parameter int FRAME_WIDTH = 10,
  parameter int DEPTH_LOG2  = 3,
  parameter int SHIFT       = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  pwm_sample_feeder_if.slave          smp,
  output logic signed [OUT_WIDTH-1:0] data_out,
  output logic                        frame_strobe,
  output logic [CNT_WIDTH-1:0]        underrun_cnt,
  output logic [CNT_WIDTH-1:0]        overflow_cnt
);

  logic [FRAME_WIDTH-1:0]      frame_cnt;
  logic                        frame_tick;
  logic                        full;
  logic                        empty;
  logic                        push;
  logic                        pop;
  logic                        drop;
  logic [IN_WIDTH-1:0]         head;
  logic signed [31:0]          shifted;
  logic signed [OUT_WIDTH-1:0] scaled;

  // Ready depends only on registered occupancy, so a same-cycle pop cannot free a slot.
  assign smp.sample_ready = !full;
  assign push             = smp.sample_valid && !full;
  assign drop             = smp.sample_valid && full;
  assign frame_tick       = &frame_cnt;
  assign pop              = frame_tick && !empty;

  sync_fifo #(
    .WIDTH      (IN_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata (smp.sample_in),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign shifted = 32'($signed(head)) >>> SHIFT;
  assign scaled  = OUT_WIDTH'(sat(shifted, 32, OUT_WIDTH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt    <= '0;
      data_out     <= '0;
      frame_strobe <= 1'b0;
      underrun_cnt <= '0;
      overflow_cnt <= '0;
    end else begin
      frame_cnt    <= frame_cnt + 1'b1;
      frame_strobe <= frame_tick;
      if (pop) data_out <= scaled;
      // An empty FIFO at the tick is an underrun even if a push lands this same cycle.
      if (frame_tick && empty && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + 1'b1;
      if (drop && (overflow_cnt != '1))                overflow_cnt <= overflow_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Scoreboard bench for pwm_sample_feeder: a reference queue tracks accepted samples per frame.
module tb_pwm_sample_feeder;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic signed [11:0] data_out;
  logic        frame_strobe;
  logic [15:0] underrun_cnt;
  logic [15:0] overflow_cnt;

  int vectors = 0;
  int miscompares = 0;

  int sb[$];
  int exp_data = 0;
  bit exp_strobe = 1'b0;
  int exp_under = 0;
  int exp_over = 0;
  int tb_cyc = 0;
  int m_occ;
  bit m_tick;
  bit m_acc;

  always #5 clk = ~clk;

  pwm_sample_feeder_if #(.IN_WIDTH(16)) smp ();

  pwm_sample_feeder dut (
    .clk          (clk),
    .rstn         (rstn),
    .smp          (smp.slave),
    .data_out     (data_out),
    .frame_strobe (frame_strobe),
    .underrun_cnt (underrun_cnt),
    .overflow_cnt (overflow_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int tb_sat(input logic [15:0] s);
    int v;
    v = int'($signed(s)) >>> 4;
    if (v > 2047)  return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // Reference model: decisions use the state before each rising edge.
  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        sb.delete();
        exp_data = 0; exp_strobe = 1'b0; exp_under = 0; exp_over = 0; tb_cyc = 0;
      end else begin
        m_occ  = sb.size();
        m_tick = ((tb_cyc % 1024) == 1023);
        m_acc  = smp.sample_valid && (m_occ < 8);
        exp_strobe = m_tick;
        if (m_tick) begin
          if (m_occ > 0) exp_data = sb.pop_front();
          else if (exp_under < 65535) exp_under++;
        end
        if (smp.sample_valid && !m_acc && exp_over < 65535) exp_over++;
        if (m_acc) sb.push_back(tb_sat(smp.sample_in));
        tb_cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        check("data_out", 32'(data_out), exp_data);
        check("strobe", 32'(frame_strobe), 32'(exp_strobe));
        check("ready", 32'(smp.sample_ready), 32'(sb.size() < 8));
        check("underrun", 32'(underrun_cnt), exp_under);
        check("overflow", 32'(overflow_cnt), exp_over);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Returns at the falling edge just before a frame_tick rising edge.
  task automatic align_tick();
    @(negedge clk);
    while ((tb_cyc % 1024) != 1023) @(negedge clk);
  endtask

  task automatic align_cyc5();
    @(negedge clk);
    while ((tb_cyc % 1024) != 5) @(negedge clk);
  endtask

  // Called at a falling edge; presents one sample for exactly one rising edge.
  task automatic drive(input logic [15:0] v);
    smp.sample_valid = 1'b1;
    smp.sample_in    = v;
    @(negedge clk);
    smp.sample_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"}, 32'(data_out), 32'd0);
    check({tag, "_strobe"}, 32'(frame_strobe), 32'd0);
    check({tag, "_under"}, 32'(underrun_cnt), 32'd0);
    check({tag, "_over"}, 32'(overflow_cnt), 32'd0);
    check({tag, "_ready"}, 32'(smp.sample_ready), 32'd1);
  endtask

  logic [15:0] burst[10];
  logic [15:0] tv;
  int          under0;
  int          over0;

  initial begin
    smp.sample_valid = 1'b0;
    smp.sample_in    = '0;
    #2 rstn = 1'b0;
    #1 check_reset_values("rst");
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Idle: three underrun frames, strobe at cycles 1024, 2048, 3072.
    for (int f = 1; f <= 3; f++) begin
      align_tick();
      @(negedge clk);
      check("idle_strobe", 32'(frame_strobe), 32'd1);
      check("idle_cycle", 32'(tb_cyc), 32'(f * 1024));
    end
    check("idle_under3", 32'(underrun_cnt), 32'd3);
    check("idle_data0", 32'(data_out), 32'd0);

    drive(16'h1230);
    align_tick();
    @(negedge clk);
    check("x1230_data", 32'(data_out), 32'h123);
    check("x1230_strobe", 32'(frame_strobe), 32'd1);

    drive(16'h7FFF);
    drive(16'h8000);
    align_tick();
    @(negedge clk);
    check("max_data", 32'(data_out), 32'd2047);
    align_tick();
    @(negedge clk);
    check("min_data", 32'(data_out), 32'hFFFF_F800);

    // Ten back-to-back samples into an empty FIFO, away from any tick.
    align_cyc5();
    for (int i = 0; i < 10; i++) burst[i] = 16'($urandom);
    for (int i = 0; i < 10; i++) drive(burst[i]);
    check("burst_ready", 32'(smp.sample_ready), 32'd0);
    check("burst_over", 32'(overflow_cnt), 32'd2);
    for (int i = 0; i < 8; i++) begin
      align_tick();
      @(negedge clk);
      check("burst_order", 32'(data_out), tb_sat(burst[i]));
    end

    // Push into an empty FIFO during the tick: underrun now, sample next frame.
    under0 = exp_under;
    tv = 16'hC350;
    align_tick();
    drive(tv);
    check("tickpush_under", 32'(underrun_cnt), 32'(under0 + 1));
    check("tickpush_hold", 32'(data_out), tb_sat(burst[7]));
    align_tick();
    @(negedge clk);
    check("tickpush_data", 32'(data_out), tb_sat(tv));

    // Full FIFO at the tick: the extra sample is dropped even though a pop happens.
    align_cyc5();
    for (int i = 0; i < 8; i++) drive(16'(i * 16'h0111 + 16'h0010));
    over0 = exp_over;
    align_tick();
    drive(16'h4444);
    check("fulltick_over", 32'(overflow_cnt), 32'(over0 + 1));
    check("fulltick_data", 32'(data_out), 32'h001);

    // Reset with five samples queued.
    align_cyc5();
    for (int i = 0; i < 5; i++) drive(16'h2000 + 16'(i));
    #2 rstn = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk);
    rstn = 1'b1;
    align_tick();
    @(negedge clk);
    check("postrst_strobe", 32'(frame_strobe), 32'd1);
    check("postrst_under", 32'(underrun_cnt), 32'd1);
    check("postrst_data", 32'(data_out), 32'd0);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_sample_feeder.md
# pwm_sample_feeder

Rate-adapting sample buffer that sits directly upstream of the audio PWM stage. It accepts demodulated signed audio samples at an arbitrary bursty rate through a valid/ready handshake and stores them in a small FIFO. Once per PWM frame it releases exactly one scaled, saturated 12-bit sample on a held output bus. Underrun and overflow events are counted for debug.

## Interface
- IN_WIDTH, 16, width of the signed input sample
- OUT_WIDTH, 12, width of the signed output sample; must equal the PWM data width
- FRAME_WIDTH, 10, frame counter width; frame length is 2^FRAME_WIDTH cycles and must equal the PWM counter width
- DEPTH_LOG2, 3, FIFO depth is 2^DEPTH_LOG2 entries
- SHIFT, 4, arithmetic right shift applied before saturation; range 0..IN_WIDTH-1
- clk  in  1  system clock; all logic is on its rising edge
- rstn  in  1  asynchronous active-low reset
- sample_in  in  IN_WIDTH  signed input sample
- sample_valid  in  1  sample_in is valid this cycle
- sample_ready  out  1  FIFO can accept a sample this cycle
- data_out  out  OUT_WIDTH  signed sample presented to the PWM, held for one full frame
- frame_strobe  out  1  one-cycle pulse in the cycle data_out takes its new value
- underrun_cnt  out  16  number of frames with no sample available; saturates at 16'hFFFF
- overflow_cnt  out  16  number of valid samples dropped because the FIFO was full; saturates at 16'hFFFF

## Operation
- Push condition: sample_valid && sample_ready. The sample is written at the FIFO tail.
- sample_ready = !full. It is combinational from the registered occupancy and does not depend on the pop in the same cycle.
- sample_valid && !sample_ready: the sample is dropped and overflow_cnt increments.
- Frame counter: FRAME_WIDTH bits, free-running, increments every cycle and wraps to 0.
- frame_tick is asserted when the counter equals all-ones.
- At a frame_tick with the FIFO not empty:
  - pop the head entry
  - data_out <= sat(head >>> SHIFT)
  - frame_strobe <= 1
- At a frame_tick with the FIFO empty:
  - data_out holds its previous value
  - frame_strobe <= 1
  - underrun_cnt increments
- sat() clamps to the range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], i.e. [-2048, 2047] at defaults. Overflowing values are never wrapped.
- Simultaneous push and pop: both occur and occupancy is unchanged.
- Push into an empty FIFO in the same cycle as frame_tick: there is no bypass. The frame counts as an underrun, and the sample is popped at the next frame.
- Occupancy is a DEPTH_LOG2+1 bit counter. Read and write pointers are DEPTH_LOG2 bits and wrap naturally.

## Timing
- Reset values:
  - sample_ready = 1
  - data_out = 0
  - frame_strobe = 0
  - both event counters = 0
  - frame counter = 0
  - FIFO empty
- Reset asserted mid-operation flushes the FIFO immediately. No sample survives reset.
- data_out and frame_strobe update on the clock edge after frame_tick. data_out therefore changes in the first cycle of each frame (frame counter == 0).
- Data latency: a sample accepted into an empty FIFO appears on data_out at the next frame boundary after its push cycle. Worst case is 2^FRAME_WIDTH cycles.
- First frame_strobe after reset release: cycle 2^FRAME_WIDTH (1024 at defaults).
- frame_strobe is high for exactly one cycle per frame.
- data_out is stable for 2^FRAME_WIDTH cycles between strobes.

## Structure
- Package pwm_feeder_pkg:
  - saturation function, parameterised by input and output width
  - counter width constant CNT_WIDTH = 16
- Sub-module sync_fifo:
  - single-clock FIFO, parameterised width and depth
  - ports: push, pop, wdata, rdata (head, first-word-fall-through), full, empty
- Top level holds:
  - frame counter
  - pop/strobe logic
  - scaling and saturation
  - event counters

## Test plan
- Reset, then no input for 3 frames -> data_out = 0; frame_strobe at cycles 1024, 2048, 3072; underrun_cnt = 3.
- Push 16'h1230 once -> at the next frame boundary data_out = 12'h123, frame_strobe = 1; data_out held for 1024 cycles.
- Push 16'h7FFF and 16'h8000 -> saturation gives data_out 2047 then -2048 on consecutive frames.
- Push 10 samples back-to-back with no pop -> sample_ready drops after 8; overflow_cnt = 2; 8 frames later the FIFO outputs the first 8 samples in order.
- Push in the same cycle as frame_tick with the FIFO empty -> underrun_cnt increments and the sample appears one frame later. Push with the FIFO full in the frame_tick cycle -> sample dropped, overflow_cnt increments.
- Assert rstn low with 5 samples queued -> outputs return to reset values immediately; after release the first frame reports an underrun.
